// File: rtl/ringosc_meas_ctrl.sv
// ringosc_meas_ctrl: ring-oscillator edge counter over a timed window; define RINGOSC_AVG_EN for 4-window averaging.
// Revision 1.0
`default_nettype none

module ringosc_meas_ctrl #(
  parameter int WIN_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_out,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

`ifdef RINGOSC_AVG_EN
  localparam int c_SHIFT = 2;
`else
  localparam int c_SHIFT = 0;
`endif

  localparam int c_ACC_W   = CNT_W + c_SHIFT;
  localparam int c_TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_WIN_LAST    = c_TMR_W'(WIN_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
  localparam logic [c_ACC_W-1:0] c_ACC_MAX     = '1;
  localparam logic [c_ACC_W-1:0] c_ACC_ONE     = c_ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_ACC_W-1:0]   r_acc;
  logic                 r_sat;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic                 w_rise;
  logic                 w_last_win;

  assign w_rise = r_sync2 & ~r_prev;
  assign busy   = (r_state != S_IDLE);

`ifdef RINGOSC_AVG_EN
  logic [1:0] r_win;

  assign w_last_win = (r_win == 2'd3);

  // Window index only advances at the end of each non-final window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= 2'd0;
    end else if (r_state == S_SETTLE) begin
      r_win <= 2'd0;
    end else if ((r_state == S_MEASURE) && (r_timer == c_WIN_LAST) && !w_last_win) begin
      r_win <= r_win + 2'd1;
    end
  end
`else
  assign w_last_win = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      ro_en   <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      r_sync1 <= ro_out;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETTLE;
            r_timer <= '0;
            ro_en   <= 1'b1;
            // Stale oscillator history must not produce a phantom edge.
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
          end
        end

        S_SETTLE: begin
          if (r_timer == c_SETTLE_LAST) begin
            r_state <= S_MEASURE;
            r_timer <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end

        S_MEASURE: begin
          if (w_rise) begin
            if (r_acc == c_ACC_MAX) begin
              r_sat <= 1'b1;
            end else begin
              r_acc <= r_acc + c_ACC_ONE;
            end
          end
          if (r_timer == c_WIN_LAST) begin
            r_timer <= '0;
            if (w_last_win) begin
              r_state <= S_DONE;
              ro_en   <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end

        S_DONE: begin
          // Top CNT_W bits of the accumulator are the average when averaging is on.
          done    <= 1'b1;
          count   <= r_acc[c_ACC_W-1 -: CNT_W];
          ovf     <= r_sat;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          ro_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
